// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl: 640x480 VGA timing, image ROM addressing and frame-latched display control
module vga_frame_ctrl #(
    parameter int DIV      = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int WIN_X0   = 192,
    parameter int WIN_Y0   = 112,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_vga,
    input  logic              image_sel,
    input  logic [7:0]        pixel_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = DIV > 1 ? $clog2(DIV) : 1;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [DW-1:0]     r_div;
    logic [HW-1:0]     r_h_cnt;
    logic [VW-1:0]     r_v_cnt;
    logic              r_cur_en;
    logic              r_cur_img;
    logic              r_hs1;
    logic              r_vs1;
    logic              r_act1;
    logic              r_win1;
    logic              w_tick;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_boundary;
    logic              w_win;
    logic              w_show;
    logic [31:0]       w_h;
    logic [31:0]       w_v;
    logic [ADDR_W-1:0] w_addr;

    assign w_h        = 32'(r_h_cnt);
    assign w_v        = 32'(r_v_cnt);
    assign w_tick     = 32'(r_div) == DIV - 1;
    assign w_h_last   = w_h == H_TOTAL - 1;
    assign w_v_last   = w_v == V_TOTAL - 1;
    assign w_boundary = w_tick && w_h_last && w_v_last;
    assign w_win      = w_h >= WIN_X0 && w_h < WIN_X0 + IMG_W && w_v >= WIN_Y0 && w_v < WIN_Y0 + IMG_H;
    assign w_addr     = ADDR_W'((r_cur_img ? 32'(IMG_W * IMG_H) : 32'd0) + (w_v - WIN_Y0) * IMG_W + (w_h - WIN_X0));
    assign w_show     = r_act1 && r_win1 && r_cur_en;

    // pixel-tick divider: one tick every DIV clocks
    always_ff @(posedge clk) begin
        if (reset)
            r_div <= '0;
        else
            r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    // raster position counters advance on each tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + 1'b1;
            if (w_h_last)
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end
    end

    // CPU controls are taken only at the frame wrap so a frame never tears
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_en    <= 1'b0;
            r_cur_img   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_boundary;
            if (w_boundary) begin
                r_cur_en  <= enable_vga;
                r_cur_img <= image_sel;
            end
        end
    end

    // stage 1: decode timing regions and issue the ROM address (held outside the window)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
            r_act1   <= 1'b0;
            r_win1   <= 1'b0;
            mem_addr <= '0;
        end else if (w_tick) begin
            r_hs1  <= !(w_h >= H_ACTIVE + H_FP && w_h < H_ACTIVE + H_FP + H_SYNC);
            r_vs1  <= !(w_v >= V_ACTIVE + V_FP && w_v < V_ACTIVE + V_FP + V_SYNC);
            r_act1 <= w_h < H_ACTIVE && w_v < V_ACTIVE;
            r_win1 <= w_win;
            if (w_win)
                mem_addr <= w_addr;
        end
    end

    // stage 2: align sync/blank with the ROM pixel returned for the stage-1 address
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
        end else if (w_tick) begin
            vga_hsync   <= r_hs1;
            vga_vsync   <= r_vs1;
            vga_blank_n <= r_act1;
            vga_r       <= w_show ? pixel_in : 8'h00;
            vga_g       <= w_show ? pixel_in : 8'h00;
            vga_b       <= w_show ? pixel_in : 8'h00;
        end
    end
endmodule

// File: tb/tb_vga_frame_ctrl.sv
// tb_vga_frame_ctrl: scaled-timing random bench against a raster-position reference model
module tb_vga_frame_ctrl;
    localparam int DIV = 2;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int IW = 8, IH = 6, WX = 4, WY = 3, AW = 7;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable_vga = 1'b0;
    logic          image_sel = 1'b0;
    logic [7:0]    pixel_in = 8'h00;
    logic [AW-1:0] mem_addr;
    logic          vga_hsync, vga_vsync, vga_blank_n, frame_start;
    logic [7:0]    vga_r, vga_g, vga_b;

    vga_frame_ctrl #(
        .DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(IW), .IMG_H(IH), .WIN_X0(WX), .WIN_Y0(WY), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .enable_vga(enable_vga), .image_sel(image_sel),
        .pixel_in(pixel_in), .mem_addr(mem_addr), .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n), .vga_r(vga_r),
        .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    bit rom_const = 1'b0;

    function automatic logic [7:0] rom(int a);
        int x;
        x = (a * 37 + 11) ^ (a >> 3);
        return rom_const ? 8'hA5 : x[7:0];
    endfunction

    // synchronous ROM: data one clock after the address
    always @(posedge clk) pixel_in <= rom(int'(mem_addr));

    function automatic bit in_win(int h, int v);
        return h >= WX && h < WX + IW && v >= WY && v < WY + IH;
    endfunction

    function automatic int addr_of(bit img, int h, int v);
        return (int'(img) * IW * IH + (v - WY) * IW + (h - WX)) % (1 << AW);
    endfunction

    int         clks, ticks;
    bit         m_en, m_img;
    logic       e_hs, e_vs, e_bl, e_fs;
    logic [7:0] e_rgb;
    int         e_addr;

    // reference: tick k scans raster position k mod FT; outputs show position k-1 after tick k
    always @(posedge clk) begin
        int p, h, v, q, qh, qv;
        if (reset) begin
            clks = 0; ticks = 0; m_en = 0; m_img = 0;
            e_hs = 1; e_vs = 1; e_bl = 0; e_fs = 0; e_rgb = 0; e_addr = 0;
        end else begin
            clks++;
            e_fs = 0;
            if (clks % DIV == 0) begin
                p = ticks % FT; h = p % HT; v = p / HT;
                if (in_win(h, v)) e_addr = addr_of(m_img, h, v);
                if (ticks > 0) begin
                    q = (ticks - 1) % FT; qh = q % HT; qv = q / HT;
                    e_hs  = !(qh >= HA + HF && qh < HA + HF + HS);
                    e_vs  = !(qv >= VA + VF && qv < VA + VF + VS);
                    e_bl  = qh < HA && qv < VA;
                    e_rgb = (e_bl && in_win(qh, qv) && m_en) ? rom(addr_of(m_img, qh, qv)) : 8'h00;
                end
                if (p == FT - 1) begin
                    m_en = enable_vga; m_img = image_sel; e_fs = 1;
                end
                ticks++;
            end
        end
    end

    int n_chk = 0, n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("hsync", 32'(vga_hsync), 32'(e_hs));
            chk("vsync", 32'(vga_vsync), 32'(e_vs));
            chk("blank_n", 32'(vga_blank_n), 32'(e_bl));
            chk("r", 32'(vga_r), 32'(e_rgb));
            chk("g", 32'(vga_g), 32'(e_rgb));
            chk("b", 32'(vga_b), 32'(e_rgb));
            chk("addr", 32'(mem_addr), 32'(e_addr));
            chk("fstart", 32'(frame_start), 32'(e_fs));
        end
    end

    task automatic run(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(int p, string tag);
        int i;
        for (i = 0; i < 2 * FT * DIV; i++) begin
            @(negedge clk);
            if ((clks + 1) % DIV == 0 && ticks % FT == p) break;
        end
        if (i == 2 * FT * DIV) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic set_rom(bit c);
        wait_pos(FT - 1, "rom");
        @(negedge clk);
        rom_const = c;
    endtask

    initial begin
        int hl, vl, bl, fs;
        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run(3);
        hl = 0; vl = 0; bl = 0; fs = 0;
        for (int i = 0; i < 2 * FT * DIV; i++) begin
            @(negedge clk);
            hl += int'(!vga_hsync); vl += int'(!vga_vsync);
            bl += int'(vga_blank_n); fs += int'(frame_start);
        end
        chk("hsync_low_clks", 32'(hl), 32'(2 * VT * HS * DIV));
        chk("vsync_low_clks", 32'(vl), 32'(2 * VS * HT * DIV));
        chk("blank_hi_clks", 32'(bl), 32'(2 * VA * HA * DIV));
        chk("fstart_count", 32'(fs), 32'd2);
        enable_vga = 1'b1; image_sel = 1'b0;
        run(2 * FT * DIV);
        wait_pos(8 * HT + 3, "midsel");
        image_sel = 1'b1;
        run(2 * FT * DIV);
        set_rom(1'b1);
        run(FT * DIV);
        enable_vga = 1'b0;
        run(2 * FT * DIV);
        enable_vga = 1'b1;
        wait_pos(8 * HT + 10, "midrst");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run(2 * FT * DIV);
        wait_pos(FT - 1, "bnd");
        image_sel = ~image_sel;
        @(negedge clk);
        image_sel = ~image_sel;
        run(2 * FT * DIV);
        set_rom(1'b0);
        for (int i = 0; i < 14000; i++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 2999) == 0) reset = 1'b1;
            if ($urandom_range(0, 39) == 0) enable_vga = ~enable_vga;
            if ($urandom_range(0, 39) == 0) image_sel = ~image_sel;
        end
        reset = 1'b0;
        run(4);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
